// File: rtl/llc_rst_flush_sequencer_pkg.sv
// Shared types for the LLC reset/flush set-walk sequencer.
package llc_rst_flush_sequencer_pkg;

  localparam int unsigned LLC_SET_BITS      = 9;
  localparam int unsigned LLC_WALK_CNT_BITS = 16;

  typedef logic [LLC_SET_BITS-1:0] llc_set_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } llc_rsf_state_t;

endpackage

// File: rtl/llc_rsf_walk_counter.sv
// Set-index counter for the rst/flush walk: synchronous clear, increment, all-ones detect.
module llc_rsf_walk_counter
  import llc_rst_flush_sequencer_pkg::*;
#(
  parameter int unsigned W = LLC_SET_BITS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         all_ones_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o      = cnt_q;
  assign all_ones_o = &cnt_q;

endmodule

// File: rtl/llc_rst_flush_sequencer.sv
// LLC reset/flush walk sequencer: one command at a time, one set per set_done pulse.
// Optional walk-duration counter built when LLC_RST_FLUSH_PERF_EN is defined.
module llc_rst_flush_sequencer
  import llc_rst_flush_sequencer_pkg::*;
#(
  parameter int unsigned SET_BITS      = LLC_SET_BITS,
  parameter int unsigned WALK_CNT_BITS = LLC_WALK_CNT_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  input  logic                     cmd_is_flush,
  output logic                     cmd_ready,
  input  logic                     set_done,
  input  logic                     abort,
  output logic                     rst_stall,
  output logic                     flush_stall,
  output logic [SET_BITS-1:0]      rst_flush_stalled_set,
  output logic                     last_set,
  output logic                     rst_flush_done,
  output logic                     done_was_flush,
  output logic [WALK_CNT_BITS-1:0] walk_cycles
);

  llc_rsf_state_t state_q, state_d;
  logic rst_stall_q, rst_stall_d;
  logic flush_stall_q, flush_stall_d;
  logic done_q, done_d;
  logic dwf_q, dwf_d;
  logic ready_q, ready_d;
  logic cnt_clr, cnt_inc, cnt_all_ones;
  logic accept;

  assign accept = (state_q == IDLE) & cmd_valid;

  llc_rsf_walk_counter #(.W(SET_BITS)) u_walk_counter (
    .clk        (clk),
    .rst_n      (rst),
    .clr_i      (cnt_clr),
    .inc_i      (cnt_inc),
    .cnt_o      (rst_flush_stalled_set),
    .all_ones_o (cnt_all_ones)
  );

  // Next-state and flag logic; abort outranks a coincident set_done.
  always_comb begin
    state_d       = state_q;
    rst_stall_d   = rst_stall_q;
    flush_stall_d = flush_stall_q;
    dwf_d         = dwf_q;
    done_d        = 1'b0;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cnt_clr       = 1'b1;
          rst_stall_d   = ~cmd_is_flush;
          flush_stall_d = cmd_is_flush;
          state_d       = WALK;
        end
      end
      WALK: begin
        if (abort) begin
          cnt_clr       = 1'b1;
          rst_stall_d   = 1'b0;
          flush_stall_d = 1'b0;
          state_d       = IDLE;
        end else if (set_done) begin
          if (cnt_all_ones) begin
            rst_stall_d   = 1'b0;
            flush_stall_d = 1'b0;
            dwf_d         = flush_stall_q;
            done_d        = 1'b1;
            state_d       = DONE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      DONE: begin
        cnt_clr = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      rst_stall_q   <= 1'b0;
      flush_stall_q <= 1'b0;
      done_q        <= 1'b0;
      dwf_q         <= 1'b0;
      ready_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      rst_stall_q   <= rst_stall_d;
      flush_stall_q <= flush_stall_d;
      done_q        <= done_d;
      dwf_q         <= dwf_d;
      ready_q       <= ready_d;
    end
  end

  assign cmd_ready      = ready_q;
  assign rst_stall      = rst_stall_q;
  assign flush_stall    = flush_stall_q;
  assign rst_flush_done = done_q;
  assign done_was_flush = dwf_q;
  assign last_set       = (state_q == WALK) & cnt_all_ones;

`ifdef LLC_RST_FLUSH_PERF_EN
  logic [WALK_CNT_BITS-1:0] perf_q, perf_inc, walk_cycles_q;

  // Snapshot includes the final WALK cycle, so it equals the cycles spent in WALK.
  assign perf_inc = (&perf_q) ? perf_q : perf_q + WALK_CNT_BITS'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q        <= '0;
      walk_cycles_q <= '0;
    end else begin
      if (accept)                 perf_q <= '0;
      else if (state_q == WALK)   perf_q <= perf_inc;
      if ((state_q == WALK) && (state_d == DONE)) walk_cycles_q <= perf_inc;
    end
  end

  assign walk_cycles = walk_cycles_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign walk_cycles   = '0;
`endif

endmodule

// File: doc/llc_rst_flush_sequencer.md
Name: llc_rst_flush_sequencer

Overview:
- Sequences LLC reset and flush operations. Owns the rst_stall/flush_stall flags and the rst_flush_stalled_set counter that the LLC input decoder uses to resume the rst/flush set-walk.
- Accepts one rst/flush command at a time and advances one set per completion pulse from the LLC main FSM.
- Signals completion after the last set (all ones) has been processed.
- Sits beside the input decoder, between the rst_tb input path and the LLC core FSM.

Parameters:
SET_BITS, 9, width of the LLC set index (matches LLC_SET_BITS).
WALK_CNT_BITS, 16, width of the optional walk-duration counter.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-low reset.
cmd_valid  in  1  rst/flush command offered (from rst_tb decode).
cmd_is_flush  in  1  1 = flush walk, 0 = reset walk; sampled with cmd_valid.
cmd_ready  out  1  high while in IDLE; command accepted when cmd_valid & cmd_ready.
set_done  in  1  pulse from core FSM: current set finished.
abort  in  1  synchronous abort of an active walk.
rst_stall  out  1  reset walk in progress.
flush_stall  out  1  flush walk in progress.
rst_flush_stalled_set  out  SET_BITS  set currently being processed.
last_set  out  1  rst_flush_stalled_set is all ones while a walk is active.
rst_flush_done  out  1  one-cycle completion pulse.
done_was_flush  out  1  type of the walk reported by rst_flush_done.
walk_cycles  out  WALK_CNT_BITS  optional; see Optional Feature.

Behaviour:
- Reset (rst low, asynchronous):
  - State is IDLE.
  - rst_stall, flush_stall, rst_flush_done and done_was_flush are 0.
  - rst_flush_stalled_set is 0; walk_cycles is 0.
- States and transitions:
  - IDLE: cmd_ready=1. On accept: set counter to 0, rst_stall = ~cmd_is_flush, flush_stall = cmd_is_flush, go to WALK. Stall outputs are visible the cycle after accept.
  - WALK: cmd_ready=0. On set_done with counter != all ones: counter increments by 1 the next cycle. On set_done with counter == all ones: clear both stalls, latch done_was_flush, go to DONE. Counter holds at all ones and never wraps to 0.
  - DONE: rst_flush_done=1 for exactly one cycle, then go to IDLE. Counter returns to 0 on entry to IDLE. cmd_ready=0 in DONE.
- Arithmetic: increment is modulo 2^SET_BITS, but the all-ones case never increments (it exits instead).
- Ignored inputs:
  - cmd_valid while not in IDLE is ignored; no queueing.
  - set_done in IDLE or DONE is ignored.
- abort:
  - In WALK: clear stalls, go to IDLE with counter = 0, and assert no done pulse.
  - abort has priority over a simultaneous set_done.
  - In IDLE or DONE, abort has no effect.
- Invariants:
  - rst_stall and flush_stall are never both 1.
  - last_set = (state == WALK) & (counter == all ones), combinational.
- Latency: a walk with no stalls between completions takes 2^SET_BITS set_done pulses. rst_flush_done fires one cycle after the final set_done.
- Reset asserted mid-walk returns everything to reset values immediately.

Optional Feature:
LLC_RST_FLUSH_PERF_EN
- Defined:
  - A WALK_CNT_BITS counter clears on command accept and increments each cycle in WALK, saturating at all ones.
  - It is copied to walk_cycles on entry to DONE and held until the next DONE; abort does not update walk_cycles.
- Undefined: the counter is not built and walk_cycles is tied to 0. The port remains present.

Decomposition:
- Shared package (cache_types/cache_consts): llc_set_t, the LLC_SET_BITS constant, and an enum llc_rsf_state_t {IDLE, WALK, DONE}.
- One natural sub-module: llc_rsf_walk_counter, a set counter with clear, increment and all-ones detect. Everything else lives in the top module.

Test Plan:
- Reset walk, SET_BITS=3: accept cmd_is_flush=0, then 8 set_done pulses. Required: counter steps 0..7, rst_stall high throughout, rst_flush_done one cycle after the 8th pulse with done_was_flush=0, counter back to 0 in IDLE.
- Flush walk with gaps: random 0–5 idle cycles between set_done pulses. Required: flush_stall only, counter advances only on set_done, done_was_flush=1.
- Command while busy: cmd_valid asserted every cycle during WALK and DONE. Required: cmd_ready=0, no re-arm, exactly one done pulse, accept resumes in IDLE.
- Abort with simultaneous set_done at counter=5. Required: IDLE next cycle, stalls 0, no done pulse, counter=0.
- Async reset at counter=3 mid-walk. Required: immediate return to reset values, then a new walk completes normally.
- LLC_RST_FLUSH_PERF_EN defined, SET_BITS=3, set_done every 2nd cycle. Required: walk_cycles = 16 at DONE and held afterwards; with the macro undefined, walk_cycles = 0.
